// File: rtl/cr_huf_comp_tlvp_usr_arb_pkg.sv
// Shared types for the Huffman compressor user-outbound TLV arbiter.
package cr_huf_comp_tlvp_usr_arb_pkg;

    localparam int CR_HUF_ARB_CNT_W = 16;

    // One TLV word on the parser user-insertion path; sot/eot delimit a TLV.
    typedef struct packed {
        logic        sot;
        logic        eot;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } tlvp_if_bus_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Circular successor of an index in 0..n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cr_huf_comp_rr_pick.sv
// Combinational circular priority pick: first set request at or after ptr.
module cr_huf_comp_rr_pick #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    // Walk the requests starting at ptr, wrapping once, and keep the first hit.
    always_comb begin
        int cand;
        cand   = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = W'(cand);
            end
        end
    end

endmodule

// File: rtl/cr_huf_comp_tlvp_usr_arb.sv
// Frame-atomic round-robin arbiter for the compressor's usr_wr/usr_tlv port.
// Optional per-requester frame counters: define CR_HUF_COMP_TLVP_ARB_STATS_EN.
//
// state    | meaning
// ARB_IDLE | no owner; pick next sot requester, drain stray non-sot heads
// ARB_LOCK | owner streams words until its eot word is transferred
module cr_huf_comp_tlvp_usr_arb
    import cr_huf_comp_tlvp_usr_arb_pkg::*;
#(
    parameter  int N_REQ = 3,
    localparam int OWN_W = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  tlvp_if_bus_t [N_REQ-1:0] req_tlv,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     usr_afull,
    input  logic                     usr_full,
    output logic                     usr_wr,
    output tlvp_if_bus_t             usr_tlv,
    output logic                     arb_busy,
    output logic [OWN_W-1:0]         arb_owner,
    output logic [N_REQ-1:0]         arb_err,
    output logic                     ovfl_err
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
   ,output logic [N_REQ-1:0][CR_HUF_ARB_CNT_W-1:0] arb_frame_cnt
`endif
);

    arb_state_e         state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   own_oh_q, own_oh_d;
    logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               first_q, first_d;
    logic               usr_wr_q, usr_wr_d;
    tlvp_if_bus_t       usr_tlv_q, usr_tlv_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic               ovfl_q, ovfl_d;
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
    logic [N_REQ-1:0][CR_HUF_ARB_CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [N_REQ-1:0]   cand;
    logic [N_REQ-1:0]   bad;
    logic [N_REQ-1:0]   pick_oh;
    logic [OWN_W-1:0]   pick_idx;
    logic               pick_any;
    logic               xfer;

    // Split heads into grantable (sot) and stray (non-sot) words.
    always_comb begin
        cand = '0;
        bad  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand[i] = req_valid[i] & req_tlv[i].sot;
            bad[i]  = req_valid[i] & ~req_tlv[i].sot;
        end
    end

    cr_huf_comp_rr_pick #(
        .N (N_REQ),
        .W (OWN_W)
    ) u_pick (
        .req    (cand),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state: grant in IDLE, stream owner words in LOCK, sticky errors.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        own_oh_d  = own_oh_q;
        rr_ptr_d  = rr_ptr_q;
        first_d   = first_q;
        usr_wr_d  = 1'b0;
        usr_tlv_d = usr_tlv_q;
        err_d     = err_q;
        ovfl_d    = ovfl_q | (usr_wr_q & usr_full);
        req_ready = '0;
        xfer      = 1'b0;
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                // Stray words are dropped here; they never block other grants.
                req_ready = bad;
                err_d     = err_q | bad;
                if (pick_any) begin
                    state_d  = ARB_LOCK;
                    owner_d  = pick_idx;
                    own_oh_d = pick_oh;
                    first_d  = 1'b1;
                end
            end
            ARB_LOCK: begin
                req_ready = own_oh_q & {N_REQ{~usr_afull}};
                xfer      = |(req_valid & req_ready);
                if (xfer) begin
                    usr_wr_d  = 1'b1;
                    usr_tlv_d = req_tlv[owner_q];
                    first_d   = 1'b0;
                    if (req_tlv[owner_q].sot && !first_q) begin
                        err_d[owner_q] = 1'b1;
                    end
                    if (req_tlv[owner_q].eot) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = OWN_W'(rr_next(int'(owner_q), N_REQ));
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
                        if (cnt_q[owner_q] != {CR_HUF_ARB_CNT_W{1'b1}}) begin
                            cnt_d[owner_q] = cnt_q[owner_q] + 1'b1;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs; rst aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            own_oh_q  <= '0;
            rr_ptr_q  <= '0;
            first_q   <= 1'b0;
            usr_wr_q  <= 1'b0;
            usr_tlv_q <= '0;
            err_q     <= '0;
            ovfl_q    <= 1'b0;
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            own_oh_q  <= own_oh_d;
            rr_ptr_q  <= rr_ptr_d;
            first_q   <= first_d;
            usr_wr_q  <= usr_wr_d;
            usr_tlv_q <= usr_tlv_d;
            err_q     <= err_d;
            ovfl_q    <= ovfl_d;
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign usr_wr    = usr_wr_q;
    assign usr_tlv   = usr_tlv_q;
    assign arb_busy  = (state_q == ARB_LOCK);
    assign arb_owner = owner_q;
    assign arb_err   = err_q;
    assign ovfl_err  = ovfl_q;
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
    assign arb_frame_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cr_huf_comp_tlvp_usr_arb.sv
// Bench for cr_huf_comp_tlvp_usr_arb; frame-level round-robin reference model.
module tb_cr_huf_comp_tlvp_usr_arb;
    import cr_huf_comp_tlvp_usr_arb_pkg::*;

    localparam int N = 3;
    localparam int OW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    tlvp_if_bus_t [N-1:0] req_tlv;
    logic [N-1:0]         req_ready;
    logic                 usr_afull;
    logic                 usr_full;
    logic                 usr_wr;
    tlvp_if_bus_t         usr_tlv;
    logic                 arb_busy;
    logic [OW-1:0]        arb_owner;
    logic [N-1:0]         arb_err;
    logic                 ovfl_err;
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
    logic [N-1:0][15:0]   arb_frame_cnt;
    int                   m_cnt [N];
`endif

    cr_huf_comp_tlvp_usr_arb #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tlv   (req_tlv),
        .req_ready (req_ready),
        .usr_afull (usr_afull),
        .usr_full  (usr_full),
        .usr_wr    (usr_wr),
        .usr_tlv   (usr_tlv),
        .arb_busy  (arb_busy),
        .arb_owner (arb_owner),
        .arb_err   (arb_err),
        .ovfl_err  (ovfl_err)
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
       ,.arb_frame_cnt (arb_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    tlvp_if_bus_t pq [N][$];
    tlvp_if_bus_t exp_q[$];
    int           exp_src[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           m_ptr   = 0;
    int           afull_pct = 0;
    bit           bubbles = 0;
    bit           prev_eot = 0;
    bit           exp_ovfl = 0;
    logic [N-1:0] rdy_seen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tlvp_if_bus_t mk(input int src, input int fr, input int w,
                                        input bit sot, input bit eot);
        tlvp_if_bus_t t;
        t.sot   = sot;
        t.eot   = eot;
        t.tuser = 8'($urandom);
        t.tdata = {8'(src), 8'(fr), 8'(w), 40'($urandom)};
        return t;
    endfunction

    task automatic add_frame(input int src, input int fr, input int len);
        for (int w = 0; w < len; w++)
            pq[src].push_back(mk(src, fr, w, w == 0, w == len - 1));
    endtask

    // Reference: whole frames leave in round-robin order from the model pointer.
    task automatic plan();
        tlvp_if_bus_t cp [N][$];
        tlvp_if_bus_t w;
        int sel;
        bit found;
        for (int i = 0; i < N; i++) cp[i] = pq[i];
        while (1) begin
            found = 0;
            sel = 0;
            for (int j = 0; j < N; j++) begin
                if (!found && cp[(m_ptr + j) % N].size() > 0) begin
                    found = 1;
                    sel = (m_ptr + j) % N;
                end
            end
            if (!found) break;
            do begin
                w = cp[sel].pop_front();
                exp_q.push_back(w);
                exp_src.push_back(sel);
            end while (!w.eot && cp[sel].size() > 0);
            m_ptr = (sel + 1) % N;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                req_tlv[i]   = pq[i][0];
                req_valid[i] = pq[i][0].sot || !bubbles || ($urandom_range(0, 3) != 0);
            end else begin
                req_tlv[i]   = '0;
                req_valid[i] = 1'b0;
            end
        end
        usr_afull = (afull_pct > 0) && (int'($urandom_range(0, 99)) < afull_pct);
    endtask

    task automatic monitor();
        int s;
        tlvp_if_bus_t e;
        if (prev_eot) chk("gap_after_eot", usr_wr, 1'b0);
        if (exp_q.size() == 0) begin
            chk("spurious_wr", usr_wr, 1'b0);
        end else if (usr_wr) begin
            e = exp_q.pop_front();
            s = exp_src.pop_front();
            chk("usr_tlv", usr_tlv, e);
            chk("arb_owner_on_wr", arb_owner, s);
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
            if (e.eot && m_cnt[s] < 65535) m_cnt[s]++;
`endif
        end
        prev_eot = usr_wr && usr_tlv.eot;
        chk("ovfl_err", ovfl_err, exp_ovfl);
        if (usr_wr && usr_full) exp_ovfl = 1;
    endtask

    task automatic cycle();
        logic [N-1:0] fired;
        drive();
        @(negedge clk);
        fired    = req_valid & req_ready;
        rdy_seen = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (fired[i]) void'(pq[i].pop_front());
        monitor();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (pq[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic run_drain(input int maxc);
        int c = 0;
        while ((exp_q.size() > 0 || pending()) && c < maxc) begin
            cycle();
            c++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (2) cycle();
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("frame_cnt", arb_frame_cnt[i], m_cnt[i]);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_usr_wr"}, usr_wr, 1'b0);
        chk({tag, "_usr_tlv"}, usr_tlv, '0);
        chk({tag, "_busy"}, arb_busy, 1'b0);
        chk({tag, "_owner"}, arb_owner, '0);
        chk({tag, "_err"}, arb_err, '0);
        chk({tag, "_ovfl"}, ovfl_err, 1'b0);
        chk({tag, "_ready"}, req_ready, '0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_tlv = '0;
        usr_afull = 1'b0;
        usr_full = 1'b0;
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All three requesters with 2-word TLVs from reset: order 0,1,2.
        for (int i = 0; i < N; i++) add_frame(i, 0, 2);
        plan();
        run_drain(100);

        // Single 4-word TLV from req0: 1-cycle arbitration, data the cycle after.
        add_frame(0, 1, 4);
        plan();
        cycle();
        chk("grant_busy", arb_busy, 1'b1);
        chk("grant_owner", arb_owner, 0);
        chk("grant_no_wr", usr_wr, 1'b0);
        cycle();
        chk("first_word_wr", usr_wr, 1'b1);
        run_drain(100);
        chk("idle_after_eot", arb_busy, 1'b0);
        chk("owner_held_idle", arb_owner, 0);

        // Pointer advanced past req0: req1 wins over req0.
        add_frame(0, 2, 1);
        add_frame(1, 2, 1);
        plan();
        run_drain(100);

        // usr_afull high for 3 cycles mid-frame.
        add_frame(0, 3, 6);
        plan();
        repeat (3) cycle();
        afull_pct = 100;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("afull_ready_low", rdy_seen[0], 1'b0);
            chk("afull_no_wr", usr_wr, 1'b0);
        end
        afull_pct = 0;
        run_drain(100);

        // Stray non-sot head from req1 in IDLE is drained and flagged.
        pq[1].push_back(mk(1, 4, 0, 1'b0, 1'b0));
        cycle();
        chk("stray_ready", rdy_seen, 3'b010);
        chk("stray_err", arb_err, 3'b010);
        chk("stray_no_grant", arb_busy, 1'b0);
        add_frame(1, 5, 3);
        plan();
        run_drain(100);
        chk("stray_err_sticky", arb_err, 3'b010);

        // sot inside a locked frame: forwarded, flagged on the owner.
        pq[0].push_back(mk(0, 6, 0, 1'b1, 1'b0));
        pq[0].push_back(mk(0, 6, 1, 1'b1, 1'b0));
        pq[0].push_back(mk(0, 6, 2, 1'b0, 1'b1));
        plan();
        run_drain(100);
        chk("inner_sot_err", arb_err, 3'b011);

        // Randomized frames with valid bubbles and random usr_afull.
        bubbles = 1;
        afull_pct = 30;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                int nf;
                nf = int'($urandom_range(0, 3));
                for (int f = 0; f < nf; f++)
                    add_frame(i, 16 + r * 4 + f, int'($urandom_range(1, 5)));
            end
            plan();
            run_drain(2000);
        end
        bubbles = 0;
        afull_pct = 0;
        chk("rand_err_unchanged", arb_err, 3'b011);

        // Write while usr_full sets the sticky overflow flag.
        usr_full = 1'b1;
        add_frame(2, 40, 1);
        plan();
        run_drain(100);
        usr_full = 1'b0;
        cycle();
        chk("ovfl_sticky", ovfl_err, 1'b1);

        // Reset during word 2 of a 5-word frame, then a clean req2 frame.
        add_frame(0, 50, 5);
        plan();
        repeat (3) cycle();
        chk("pre_rst_busy", arb_busy, 1'b1);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        exp_q.delete();
        exp_src.delete();
        req_valid = '0;
        req_tlv = '0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        prev_eot = 0;
        exp_ovfl = 0;
`ifdef CR_HUF_COMP_TLVP_ARB_STATS_EN
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        @(posedge clk);
        #1;
        add_frame(2, 60, 3);
        plan();
        cycle();
        chk("post_rst_owner", arb_owner, 2);
        run_drain(100);
        chk("post_rst_err", arb_err, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cr_huf_comp_tlvp_usr_arb.md
Name: cr_huf_comp_tlvp_usr_arb

Overview:
- Frame-atomic round-robin arbiter for the Huffman compressor's user-outbound TLV write port (the `usr_wr`/`usr_tlv` insertion path of the compressor's TLV parser top).
- Lets N_REQ internal producers (e.g. stats, trailer, footer generators) share one `usr_wr`/`usr_tlv` port.
- Once granted, a requester keeps the port from its sot word through its eot word, so TLVs never interleave.
- Output is registered and throttled by the parser's `usr_afull`.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- OWN_W, $clog2(N_REQ), owner index width (derived, do not override).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  requester i presents a word on req_tlv[i]
- req_tlv  in  N_REQ x tlvp_if_bus_t  requester words; sot/eot fields delimit a TLV
- req_ready  out  N_REQ  word on requester i accepted this cycle when valid&ready
- usr_afull  in  1  parser user-ob almost full (threshold >= 2)
- usr_full  in  1  parser user-ob full (checking only)
- usr_wr  out  1  registered write strobe to the parser
- usr_tlv  out  tlvp_if_bus_t  registered write data
- arb_busy  out  1  state == LOCK
- arb_owner  out  OWN_W  current/last owner index
- arb_err  out  N_REQ  sticky per-requester protocol error
- ovfl_err  out  1  sticky: usr_wr issued while usr_full

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr 0. Asserting rst mid-frame aborts immediately; the partial TLV is not completed. Producers must also be reset.
- States: IDLE, LOCK.
- IDLE:
  - Candidates are the requesters with req_valid=1 and req_tlv.sot=1.
  - Pick the first candidate at or after rr_ptr (circular). Register it as owner, go to LOCK next cycle.
  - No data transfers in IDLE (1-cycle arbitration latency).
- IDLE, head word without sot:
  - req_valid=1 with sot=0 from a requester: req_ready=1 for that requester, the word is discarded, arb_err[i] is set.
  - Several such requesters are all drained the same cycle.
  - This has priority over granting that requester but not over granting others.
- LOCK:
  - req_ready[owner] = !usr_afull. All other req_ready = 0.
  - On valid&ready: the next cycle has usr_wr=1 and usr_tlv=word. Otherwise usr_wr=0 next cycle.
  - A transferred word with eot=1 → IDLE, rr_ptr = (owner+1) mod N_REQ.
  - Minimum one idle cycle on usr_wr between consecutive TLVs.
  - A sot=1 word inside LOCK (other than the first) sets arb_err[owner] but is still forwarded.
  - A single word with sot=1 and eot=1 is a complete TLV: 1 word, then return to IDLE.
- Backpressure:
  - usr_afull sampled at cycle t gates the transfer at t, which appears on usr_wr at t+1. The afull threshold >= 2 guarantees no overflow.
  - usr_wr asserted while usr_full=1 sets ovfl_err.
- No timeout: an owner may hold LOCK indefinitely while not asserting valid.
- Fairness: every requester with a pending sot word is granted within N_REQ-1 other frames.
- arb_owner holds its value in IDLE. arb_err and ovfl_err clear only on rst.

Optional Feature:
- Macro: CR_HUF_COMP_TLVP_ARB_STATS_EN.
- Defined: adds output arb_frame_cnt (N_REQ x 16). Per-requester saturating count of completed frames (eot transfers); holds at 16'hFFFF; reset to 0.
- Not defined: the port is absent and no counter flops are built. Arbitration behaviour is identical.

Decomposition:
- Shared package (cr_structs / cr_native_types): reuse tlvp_if_bus_t. Add arb_state_e {ARB_IDLE, ARB_LOCK} and a localparam CR_HUF_ARB_CNT_W = 16.
- Sub-module cr_huf_comp_rr_pick: combinational circular priority pick. Inputs: req vector and rr_ptr. Outputs: onehot, index, any. Reusable by other arbiters in the compressor.

Test Plan:
- Single requester: req0 sends a 4-word TLV (sot on w0, eot on w3), afull=0 → grant cycle 1, usr_wr high cycles 3-6 with w0..w3, then IDLE, rr_ptr=1.
- All three requesters present 2-word TLVs simultaneously from reset → output order req0, req1, req2, with exactly 1 idle cycle between frames; arb_owner 0, 1, 2.
- usr_afull toggled high for 3 cycles mid-frame → req_ready[owner]=0 in those cycles, no usr_wr the following cycles, no word lost or duplicated, ovfl_err=0.
- req1 presents sot=0 while IDLE → word dropped, arb_err=3'b010; a later valid req1 frame is still forwarded correctly.
- rst pulsed during word 2 of a 5-word frame → all outputs 0 asynchronously; after release a new req2 frame is granted cleanly.
- STATS_EN build: 70000 one-word frames from req0 → arb_frame_cnt[0] saturates at 16'hFFFF; counts for the other requesters stay 0.
